bcd_counter4: RTL and testbench

BCD_COUNTER4 -- requirements
Module: bcd_counter4

---
 rtl/bcd_counter4.sv | 118 +++++++++++
 tb/tb_bcd_counter4.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/bcd_counter4.sv
// Four-digit BCD up/down counter with count prescaler, clear/load, wrap flag
// and a free-running digit-scan strobe for a multiplexed display.
module bcd_counter4 #(
    parameter int COUNT_DIV = 4,
    parameter int SCAN_DIV  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        up,
    input  logic        clr,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] bcd,
    output logic        count_tick,
    output logic        wrap,
    output logic        scan_tick
);

    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(COUNT_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    logic [PW-1:0] r_pre;
    logic [SW-1:0] r_scan;
    logic [15:0]   r_bcd;
    logic          r_count_tick;
    logic          r_wrap;
    logic          r_scan_tick;

    logic [15:0]   w_next;
    logic [15:0]   w_load_clean;
    logic          w_c;
    logic          w_full;

    // Ripple carry/borrow across digits; w_full is the carry out of digit 3.
    always_comb begin
        w_next = r_bcd;
        w_c    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (w_c) begin
                if (up) begin
                    if (r_bcd[4*i +: 4] >= 4'd9) begin
                        w_next[4*i +: 4] = 4'd0;
                    end else begin
                        w_next[4*i +: 4] = r_bcd[4*i +: 4] + 4'd1;
                        w_c = 1'b0;
                    end
                end else begin
                    if (r_bcd[4*i +: 4] == 4'd0 || r_bcd[4*i +: 4] > 4'd9) begin
                        w_next[4*i +: 4] = 4'd9;
                    end else begin
                        w_next[4*i +: 4] = r_bcd[4*i +: 4] - 4'd1;
                        w_c = 1'b0;
                    end
                end
            end
        end
        w_full = w_c;
    end

    // Illegal load digits are forced to zero so bcd never carries a non-BCD code.
    always_comb begin
        w_load_clean = load_val;
        for (int i = 0; i < 4; i++) begin
            if (load_val[4*i +: 4] > 4'd9)
                w_load_clean[4*i +: 4] = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pre        <= '0;
            r_bcd        <= '0;
            r_count_tick <= 1'b0;
            r_wrap       <= 1'b0;
        end else begin
            r_count_tick <= 1'b0;
            r_wrap       <= 1'b0;
            if (clr) begin
                r_bcd <= '0;
                r_pre <= '0;
            end else if (load) begin
                r_bcd <= w_load_clean;
                r_pre <= '0;
            end else if (en) begin
                if (r_pre == PRE_LAST) begin
                    r_pre        <= '0;
                    r_bcd        <= w_next;
                    r_count_tick <= 1'b1;
                    r_wrap       <= w_full;
                end else begin
                    r_pre <= r_pre + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scan      <= '0;
            r_scan_tick <= 1'b0;
        end else if (r_scan == SCAN_LAST) begin
            r_scan      <= '0;
            r_scan_tick <= 1'b1;
        end else begin
            r_scan      <= r_scan + 1'b1;
            r_scan_tick <= 1'b0;
        end
    end

    assign bcd        = r_bcd;
    assign count_tick = r_count_tick;
    assign wrap       = r_wrap;
    assign scan_tick  = r_scan_tick;

endmodule

// File: tb/tb_bcd_counter4.sv
// Directed bench for bcd_counter4 at default parameters (COUNT_DIV=4, SCAN_DIV=3).
module tb_bcd_counter4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        up = 1'b1;
    logic        clr = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'h0000;
    logic [15:0] bcd;
    logic        count_tick;
    logic        wrap;
    logic        scan_tick;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [15:0] m_bcd = 16'h0000;

    bcd_counter4 dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .bcd(bcd), .count_tick(count_tick),
        .wrap(wrap), .scan_tick(scan_tick)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; scan_tick expected whenever this is a multiple of 3.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc1();
        @(posedge clk);
        #1;
        chk("scan_tick", scan_tick, (cyc % 3 == 0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc1();
            chk("idle_tick", count_tick, 0);
            chk("idle_wrap", wrap, 0);
            chk("idle_bcd", bcd, m_bcd);
        end
    endtask

    task automatic step(input logic [15:0] exp_bcd, input logic exp_wrap);
        idle(3);
        cyc1();
        chk("step_tick", count_tick, 1);
        chk("step_bcd", bcd, exp_bcd);
        chk("step_wrap", wrap, exp_wrap);
        m_bcd = exp_bcd;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [15:0] exp_bcd);
        load = 1'b1;
        load_val = v;
        cyc1();
        load = 1'b0;
        chk("load_bcd", bcd, exp_bcd);
        chk("load_tick", count_tick, 0);
        chk("load_wrap", wrap, 0);
        m_bcd = exp_bcd;
    endtask

    initial begin
        #2;
        chk("rst_bcd", bcd, 16'h0000);
        chk("rst_tick", count_tick, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_scan", scan_tick, 0);

        // Free count from reset: ticks every 4th cycle, 0000 -> 0010 after 10 ticks.
        @(negedge clk);
        rst = 1'b1;
        en = 1'b1;
        up = 1'b1;
        for (int k = 1; k <= 10; k++)
            step(16'(((k / 10) << 4) | (k % 10)), 1'b0);

        // Up through 9999 -> 0000 wrap.
        do_load(16'h9998, 16'h9998);
        step(16'h9999, 1'b0);
        step(16'h0000, 1'b1);
        step(16'h0001, 1'b0);

        // Down through 0000 -> 9999 wrap, then borrow without wrap.
        up = 1'b0;
        do_load(16'h0001, 16'h0001);
        step(16'h0000, 1'b0);
        step(16'h9999, 1'b1);
        do_load(16'h0100, 16'h0100);
        step(16'h0099, 1'b0);

        // clr beats load exactly on the step edge.
        up = 1'b1;
        do_load(16'h0005, 16'h0005);
        idle(3);
        clr = 1'b1;
        load = 1'b1;
        load_val = 16'h1234;
        cyc1();
        clr = 1'b0;
        load = 1'b0;
        chk("clr_bcd", bcd, 16'h0000);
        chk("clr_tick", count_tick, 0);
        chk("clr_wrap", wrap, 0);
        m_bcd = 16'h0000;
        do_load(16'h1A3F, 16'h1030);
        step(16'h1031, 1'b0);

        // en dropped with prescaler at 2 for 7 cycles.
        idle(2);
        en = 1'b0;
        idle(7);
        en = 1'b1;
        idle(1);
        cyc1();
        chk("resume_tick", count_tick, 1);
        chk("resume_bcd", bcd, 16'h1032);
        m_bcd = 16'h1032;

        // Asynchronous reset mid-period.
        do_load(16'h0456, 16'h0456);
        idle(1);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_bcd", bcd, 16'h0000);
        chk("arst_tick", count_tick, 0);
        chk("arst_scan", scan_tick, 0);
        m_bcd = 16'h0000;
        @(negedge clk);
        rst = 1'b1;
        step(16'h0001, 1'b0);
        step(16'h0002, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got 0 expected 1");
        $fatal(1);
    end

endmodule
